// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared processor encodings for fetch and controller
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BT_NONE   = 2'd0,
        BT_JUMP   = 2'd1,
        BT_JR     = 2'd2,
        BT_BRANCH = 2'd3
    } branch_type_e;

    typedef enum logic {
        ST_BUBBLE = 1'b0,
        ST_RUN    = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] PC_STRIDE = 32'd4;

    // Instruction memory is word addressed; any stray low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational redirect decision and target address
module branch_target_calc
    import instruction_fetch_unit_pkg::*;
(
    input  logic [1:0]  branch_type_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_base_pc_i,
    input  logic [31:0] branch_offset_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] jr_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    branch_type_e branch_type;
    logic [31:0]  raw_target;

    assign branch_type = branch_type_e'(branch_type_i);

    always_comb begin
        redirect_o = 1'b0;
        raw_target = branch_base_pc_i;
        case (branch_type)
            BT_JUMP: begin
                redirect_o = 1'b1;
                raw_target = {branch_base_pc_i[31:28], jump_index_i, 2'b00};
            end
            BT_JR: begin
                redirect_o = 1'b1;
                raw_target = jr_target_i;
            end
            BT_BRANCH: begin
                redirect_o = branch_taken_i;
                raw_target = branch_base_pc_i + (branch_offset_i << 2);
            end
            default: begin
                redirect_o = 1'b0;
                raw_target = branch_base_pc_i;
            end
        endcase
        target_o = word_align(raw_target);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, IF/ID pipeline register and fetch control FSM
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_data_i,
    input  logic        stall_i,
    input  logic [1:0]  branch_type_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_base_pc_i,
    input  logic [31:0] branch_offset_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] ifid_instruction_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic        ifid_valid_o,
    output logic [5:0]  inst_code_o,
    output logic [5:0]  funct_code_o,
    output logic [4:0]  reg_imm_o,
    output logic [31:0] fetch_count_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic [31:0]  pc_plus4;

    branch_target_calc u_target (
        .branch_type_i    (branch_type_i),
        .branch_taken_i   (branch_taken_i),
        .branch_base_pc_i (branch_base_pc_i),
        .branch_offset_i  (branch_offset_i),
        .jump_index_i     (jump_index_i),
        .jr_target_i      (jr_target_i),
        .redirect_o       (redirect),
        .target_o         (redirect_target)
    );

    assign pc_plus4 = pc_q + PC_STRIDE;

    // Redirect beats stall so a resolved branch is never lost behind a hazard.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc4_d    = ifid_pc4_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            pc_d         = redirect_target;
            ifid_instr_d = NOP_WORD;
            state_d      = ST_BUBBLE;
        end else if (!stall_i) begin
            pc_d          = pc_plus4;
            ifid_instr_d  = inst_data_i;
            ifid_pc4_d    = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
            state_d       = ST_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_BUBBLE;
            pc_q          <= RESET_PC;
            ifid_instr_q  <= NOP_WORD;
            ifid_pc4_q    <= 32'h0000_0000;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc4_q    <= ifid_pc4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign inst_addr_o        = pc_q;
    assign ifid_instruction_o = ifid_instr_q;
    assign ifid_pc_plus4_o    = ifid_pc4_q;
    assign ifid_valid_o       = (state_q == ST_RUN);
    assign fetch_count_o      = fetch_count_q;
    assign inst_code_o        = ifid_instr_q[31:26];
    assign funct_code_o       = ifid_instr_q[5:0];
    assign reg_imm_o          = ifid_instr_q[20:16];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector table, corner sequences and randomized model checks
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        stall;
    logic [1:0]  btype;
    logic        taken;
    logic [31:0] base_pc;
    logic [31:0] offset;
    logic [25:0] jidx;
    logic [31:0] jr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [5:0]  inst_code;
    logic [5:0]  funct_code;
    logic [4:0]  reg_imm;
    logic [31:0] fetch_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    assign inst_data = tag(inst_addr);

    instruction_fetch_unit dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .inst_addr_o        (inst_addr),
        .inst_data_i        (inst_data),
        .stall_i            (stall),
        .branch_type_i      (btype),
        .branch_taken_i     (taken),
        .branch_base_pc_i   (base_pc),
        .branch_offset_i    (offset),
        .jump_index_i       (jidx),
        .jr_target_i        (jr),
        .ifid_instruction_o (ifid_instr),
        .ifid_pc_plus4_o    (ifid_pc4),
        .ifid_valid_o       (ifid_valid),
        .inst_code_o        (inst_code),
        .funct_code_o       (funct_code),
        .reg_imm_o          (reg_imm),
        .fetch_count_o      (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] t, input logic tk,
                         input logic [31:0] b, input logic [31:0] o, input logic [25:0] j,
                         input logic [31:0] jt);
        @(negedge clk);
        reset = r; stall = s; btype = t; taken = tk;
        base_pc = b; offset = o; jidx = j; jr = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic [1:0]  btype;
        logic        taken;
        logic [31:0] base;
        logic [31:0] offset;
        logic [25:0] jidx;
        logic [31:0] jr;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [31:0] exp_count;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic [1:0] t, input logic tk,
                                input logic [31:0] b, input logic [31:0] o, input logic [25:0] j,
                                input logic [31:0] jt, input logic [31:0] pc, input logic v,
                                input logic [31:0] c, input logic [31:0] p4);
        vec_t x;
        x.stall = s; x.btype = t; x.taken = tk; x.base = b; x.offset = o; x.jidx = j; x.jr = jt;
        x.exp_pc = pc; x.exp_valid = v; x.exp_count = c; x.exp_pc4 = p4;
        return x;
    endfunction

    // Reference model state: a plain description of the fetch rules.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid;

    task automatic model_step(input logic r, input logic s, input logic [1:0] t, input logic tk,
                              input logic [31:0] b, input logic [31:0] o, input logic [25:0] j,
                              input logic [31:0] jt);
        logic        go;
        logic [31:0] tgt;
        go  = (t == 2'd1) || (t == 2'd2) || (t == 2'd3 && tk);
        tgt = (t == 2'd1) ? {b[31:28], j, 2'b00} :
              (t == 2'd2) ? jt : b + o * 32'd4;
        tgt = tgt & ~32'd3;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        end else if (go) begin
            m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = tag(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; btype = 2'd0; taken = 1'b0;
        base_pc = 32'h0; offset = 32'h0; jidx = 26'h0; jr = 32'h0;
        @(posedge clk); tick();
        check("reset_pc", inst_addr, 32'h0);
        check("reset_valid", {31'h0, ifid_valid}, 32'h0);
        check("reset_instr", ifid_instr, 32'h0);
        check("reset_pc4", ifid_pc4, 32'h0);
        check("reset_count", fetch_count, 32'h0);

        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 32'h4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 2, 32'h8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hC, 1, 3, 32'hC));
        vecs.push_back(mk(0, 1, 0, 32'h9000_0010, 0, 26'h0000100, 0, 32'h9000_0400, 0, 3, 0));
        vecs.push_back(mk(0, 2, 0, 0, 0, 0, 32'h0000_1236, 32'h0000_1234, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h1238, 1, 4, 32'h1238));
        vecs.push_back(mk(0, 3, 0, 32'h40, 32'hFFFF_FFFE, 0, 0, 32'h123C, 1, 5, 32'h123C));
        vecs.push_back(mk(0, 2, 0, 0, 0, 0, 32'h40, 32'h40, 0, 5, 0));
        vecs.push_back(mk(0, 3, 1, 32'h40, 32'hFFFF_FFFE, 0, 0, 32'h38, 0, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3C, 1, 6, 32'h3C));
        vecs.push_back(mk(0, 2, 0, 0, 0, 0, 32'h40, 32'h40, 0, 6, 0));
        vecs.push_back(mk(0, 3, 0, 32'h40, 32'hFFFF_FFFE, 0, 0, 32'h44, 1, 7, 32'h44));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h44, 1, 7, 32'h44));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h44, 1, 7, 32'h44));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h44, 1, 7, 32'h44));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h44, 1, 7, 32'h44));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h44, 1, 7, 32'h44));
        vecs.push_back(mk(1, 2, 0, 0, 0, 0, 32'h100, 32'h100, 0, 7, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h100, 0, 7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h104, 1, 8, 32'h104));
        vecs.push_back(mk(0, 2, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 9, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].stall, vecs[i].btype, vecs[i].taken, vecs[i].base,
                  vecs[i].offset, vecs[i].jidx, vecs[i].jr);
            tick();
            check($sformatf("vec%0d_pc", i), inst_addr, vecs[i].exp_pc);
            check($sformatf("vec%0d_valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].exp_valid});
            check($sformatf("vec%0d_count", i), fetch_count, vecs[i].exp_count);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc4", i), ifid_pc4, vecs[i].exp_pc4);
                check($sformatf("vec%0d_instr", i), ifid_instr, tag(vecs[i].exp_pc4 - 32'd4));
            end else begin
                check($sformatf("vec%0d_bubble", i), ifid_instr, 32'h0);
            end
        end

        // Reset overrides a concurrent stall and redirect.
        drive(1, 1, 2'd2, 0, 0, 0, 0, 32'h500);
        tick();
        check("rst_ovr_pc", inst_addr, 32'h0);
        check("rst_ovr_valid", {31'h0, ifid_valid}, 32'h0);
        check("rst_ovr_instr", ifid_instr, 32'h0);
        check("rst_ovr_pc4", ifid_pc4, 32'h0);
        check("rst_ovr_count", fetch_count, 32'h0);
        drive(0, 0, 2'd0, 0, 0, 0, 0, 0);
        tick();
        check("rst_rel_pc", inst_addr, 32'h4);
        check("rst_rel_instr", ifid_instr, tag(32'h0));
        check("rst_rel_count", fetch_count, 32'h1);
        check("slice_code", {26'h0, inst_code}, {26'h0, tag(32'h0) >> 26});
        check("slice_funct", {26'h0, funct_code}, {26'h0, tag(32'h0) & 32'h3F});

        // Randomized run against the reference model.
        drive(1, 0, 2'd0, 0, 0, 0, 0, 0);
        model_step(1, 0, 2'd0, 0, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 400; n++) begin
            logic        r, s, tk;
            logic [1:0]  t;
            logic [31:0] b, o, jt;
            logic [25:0] j;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            tk = 1'($urandom);
            b  = $urandom;
            o  = $urandom_range(0, 1) ? $urandom : 32'($signed(16'($urandom)));
            j  = 26'($urandom);
            jt = $urandom;
            drive(r, s, t, tk, b, o, j, jt);
            model_step(r, s, t, tk, b, o, j, jt);
            tick();
            check($sformatf("rnd%0d_pc", n), inst_addr, m_pc);
            check($sformatf("rnd%0d_valid", n), {31'h0, ifid_valid}, {31'h0, m_valid});
            check($sformatf("rnd%0d_count", n), fetch_count, m_count);
            check($sformatf("rnd%0d_instr", n), ifid_instr, m_instr);
            if (m_valid)
                check($sformatf("rnd%0d_pc4", n), ifid_pc4, m_pc4);
            check($sformatf("rnd%0d_regimm", n), {27'h0, reg_imm}, {27'h0, m_instr[20:16]});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 InstAddr  output  32  byte address to instruction memory; equals PC.
REQ-005 InstData  input  32  instruction word; combinational read of InstAddr in the same cycle.
REQ-006 Stall  input  1  hold PC and IF/ID contents.
REQ-007 BranchType  input  2  redirect type from ID stage: 0 none, 1 j/jal, 2 jr, 3 conditional branch.
REQ-008 BranchTaken  input  1  conditional branch outcome; used only when BranchType=3.
REQ-009 BranchBasePC  input  32  PC+4 of the redirecting instruction.
REQ-010 BranchOffset  input  32  sign-extended 16-bit branch immediate, in words.
REQ-011 JumpIndex  input  26  j/jal target field.
REQ-012 JrTarget  input  32  register value for jr.
REQ-013 IFID_Instruction  output  32  registered fetched instruction.
REQ-014 IFID_PCPlus4  output  32  registered PC+4 of that instruction; also the jal link value.
REQ-015 IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 InstCode / FunctCode / RegImm  output  6/6/5  IFID_Instruction[31:26]/[5:0]/[20:16], feeding the controller.
REQ-017 FetchCount  output  32  count of instructions accepted into IF/ID.

Function
REQ-018 Redirect SHALL assert when BranchType is 1 or 2, or BranchType=3 with BranchTaken=1; BranchType=3 with BranchTaken=0 SHALL NOT redirect.
REQ-019 Redirect target SHALL be: type 1 {BranchBasePC[31:28], JumpIndex, 2'b00}; type 2 JrTarget; type 3 BranchBasePC + (BranchOffset << 2), modulo 2^32.
REQ-020 Per-edge priority SHALL be Reset > Redirect > Stall > normal fetch.
REQ-021 Normal fetch: PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0); IF/ID <= {InstData, PC+4}; IFID_Valid <= 1; FetchCount += 1.
REQ-022 Stall without redirect: PC, IF/ID, IFID_Valid, FetchCount SHALL hold.
REQ-023 Redirect (stalled or not): PC <= target; IFID_Instruction <= 0; IFID_Valid <= 0; FetchCount holds.
REQ-024 Fetch-to-IF/ID latency SHALL be one cycle; the instruction at a redirect target SHALL appear in IF/ID exactly two edges after the redirect cycle.
REQ-025 Control state machine: BUBBLE (after reset or redirect; IFID_Valid=0) and RUN (IFID_Valid=1); BUBBLE->RUN on normal fetch; RUN->BUBBLE on redirect; any state->BUBBLE on reset; Stall holds state.
REQ-026 Misaligned targets (bits [1:0] != 0) SHALL be forced word-aligned by clearing bits [1:0].
REQ-027 FetchCount SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 InstCode/FunctCode/RegImm SHALL be pure combinational slices of IFID_Instruction.

Reset
REQ-029 On Reset: PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0, state=BUBBLE.
REQ-030 Reset mid-stall or concurrent with redirect SHALL override both; first fetch from RESET_PC occurs on the edge after Reset deasserts.

Structure
REQ-031 BranchType encodings (NONE/JUMP/JR/BRANCH), the NOP word, and state encodings SHALL live in the shared processor package used by the controller.
REQ-032 Target computation SHALL be one combinational sub-module, branch_target_calc; PC, IF/ID register, and FSM stay in the top.

Verification
REQ-033 Reset, 3 free-running cycles, InstData=addr-tagged words -> IFID_PCPlus4 = 4, 8, 12; IFID_Valid=1 from 2nd edge; FetchCount=3.
REQ-034 PC=0x40, BranchType=3, BranchTaken=1, BranchBasePC=0x40, BranchOffset=0xFFFF_FFFE -> next PC=0x38; one bubble; BranchTaken=0 -> PC=0x44, no bubble.
REQ-035 BranchType=1, BranchBasePC=0x9000_0010, JumpIndex=26'h0000100 -> PC=0x9000_0400; BranchType=2, JrTarget=0x0000_1236 -> PC=0x0000_1234.
REQ-036 Stall held 4 cycles -> PC, IF/ID, FetchCount unchanged; redirect in 2nd stall cycle -> PC=target and IFID_Valid=0 immediately.
REQ-037 PC=0xFFFF_FFFC normal fetch -> PC=0; Reset asserted with Stall and redirect both high -> all REQ-029 values next edge.
